// File: rtl/id_stage_ctrl.sv
// Decode-stage front controller: two-entry skid buffer, immediate/format decode on the input side, flush, stall counter.
// Optional build macro DEC_ILLEGAL_EN adds a registered illegal-opcode flag; otherwise id_illegal is tied low.
`ifndef BUS_W
`define BUS_W 32
`endif

module id_stage_ctrl #(
   parameter int PC_W        = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_if_valid,
   output logic                   o_if_ready,
   input  logic [`BUS_W-1:0]      i_if_inst,
   input  logic [PC_W-1:0]        i_if_pc,
   input  logic                   i_flush,
   output logic                   o_id_valid,
   input  logic                   i_id_ready,
   output logic [`BUS_W-1:0]      o_id_inst,
   output logic [PC_W-1:0]        o_id_pc,
   output logic [`BUS_W-1:0]      o_id_imm,
   output logic [2:0]             o_id_fmt,
   output logic                   o_id_illegal,
   output logic [STALL_CNT_W-1:0] o_stall_cnt
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_IL = 7'b0000011;
   localparam logic [6:0] OP_IJ = 7'b1100111;
   localparam logic [6:0] OP_IE = 7'b1110011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_U  = 7'b0110111;
   localparam logic [6:0] OP_UA = 7'b0010111;
   localparam logic [6:0] OP_J  = 7'b1101111;

   logic [1:0]             r_state;
   logic [1:0]             w_stateNext;
   logic [`BUS_W-1:0]      r_inst;
   logic [`BUS_W-1:0]      r_imm;
   logic [PC_W-1:0]        r_pc;
   logic [2:0]             r_fmt;
   logic [`BUS_W-1:0]      r_skidInst;
   logic [`BUS_W-1:0]      r_skidImm;
   logic [PC_W-1:0]        r_skidPc;
   logic [2:0]             r_skidFmt;
   logic [STALL_CNT_W-1:0] r_stallCnt;

   logic [6:0]        w_opcode;
   logic [2:0]        w_fmt;
   logic [`BUS_W-1:0] w_imm;
   logic              w_push;
   logic              w_pop;
   logic              w_loadMainIn;
   logic              w_loadMainSkid;
   logic              w_loadSkid;

   assign w_opcode   = i_if_inst[6:0];
   assign o_if_ready = (r_state != ST_FULL) & ~i_flush;
   assign o_id_valid = (r_state != ST_EMPTY);
   assign w_push     = i_if_valid & o_if_ready;
   assign w_pop      = o_id_valid & i_id_ready;

   always_comb begin
      w_fmt = 3'd0;
      case (w_opcode)
         OP_I, OP_IL, OP_IJ, OP_IE: w_fmt = 3'd1;
         OP_S:                      w_fmt = 3'd2;
         OP_B:                      w_fmt = 3'd3;
         OP_U, OP_UA:               w_fmt = 3'd4;
         OP_J:                      w_fmt = 3'd5;
         default:                   w_fmt = 3'd0;
      endcase
   end

   // Splicer_Imm: reassemble the scattered immediate fields per format, sign-extended from bit 31.
   always_comb begin
      w_imm = '0;
      case (w_fmt)
         3'd1: w_imm = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
         3'd2: w_imm = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
         3'd3: w_imm = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                        i_if_inst[30:25], i_if_inst[11:8], 1'b0};
         3'd4: w_imm = {i_if_inst[31:12], 12'd0};
         3'd5: w_imm = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12],
                        i_if_inst[20], i_if_inst[30:21], 1'b0};
         default: w_imm = '0;
      endcase
   end

   always_comb begin
      w_stateNext    = r_state;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
      if (i_flush) begin
         w_stateNext = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_stateNext  = ST_ONE;
                  w_loadMainIn = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_loadMainIn = 1'b1;
               end else if (w_push) begin
                  w_stateNext = ST_FULL;
                  w_loadSkid  = 1'b1;
               end else if (w_pop) begin
                  w_stateNext = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_stateNext    = ST_ONE;
                  w_loadMainSkid = 1'b1;
               end
            end
            default: w_stateNext = ST_EMPTY;
         endcase
      end
   end

   // Data registers keep stale contents on flush; only the state (and hence id_valid) clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_inst     <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_fmt      <= 3'd0;
         r_skidInst <= '0;
         r_skidImm  <= '0;
         r_skidPc   <= '0;
         r_skidFmt  <= 3'd0;
      end else begin
         r_state <= w_stateNext;
         if (w_loadMainIn) begin
            r_inst <= i_if_inst;
            r_imm  <= w_imm;
            r_pc   <= i_if_pc;
            r_fmt  <= w_fmt;
         end else if (w_loadMainSkid) begin
            r_inst <= r_skidInst;
            r_imm  <= r_skidImm;
            r_pc   <= r_skidPc;
            r_fmt  <= r_skidFmt;
         end
         if (w_loadSkid) begin
            r_skidInst <= i_if_inst;
            r_skidImm  <= w_imm;
            r_skidPc   <= i_if_pc;
            r_skidFmt  <= w_fmt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
      end else if (o_id_valid && !i_id_ready && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

`ifdef DEC_ILLEGAL_EN
   localparam logic [6:0] OP_R = 7'b0110011;

   logic w_illegal;
   logic r_illegal;
   logic r_skidIllegal;

   assign w_illegal = (w_fmt == 3'd0) & (w_opcode != OP_R);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal     <= 1'b0;
         r_skidIllegal <= 1'b0;
      end else begin
         if (w_loadMainIn) begin
            r_illegal <= w_illegal;
         end else if (w_loadMainSkid) begin
            r_illegal <= r_skidIllegal;
         end
         if (w_loadSkid) begin
            r_skidIllegal <= w_illegal;
         end
      end
   end

   assign o_id_illegal = r_illegal;
`else
   assign o_id_illegal = 1'b0;
`endif

   assign o_id_inst   = r_inst;
   assign o_id_pc     = r_pc;
   assign o_id_imm    = r_imm;
   assign o_id_fmt    = r_fmt;
   assign o_stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_id_stage_ctrl;

   localparam int PC_W = 32;
   localparam int SW   = 10;
   localparam int SAT  = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ifValid = 1'b0;
   logic          ifReady;
   logic [31:0]   ifInst = '0;
   logic [31:0]   ifPc = '0;
   logic          flush = 1'b0;
   logic          idValid;
   logic          idReady = 1'b0;
   logic [31:0]   idInst;
   logic [31:0]   idPc;
   logic [31:0]   idImm;
   logic [2:0]    idFmt;
   logic          idIllegal;
   logic [SW-1:0] stallCnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t      q[$];
   int unsigned mStall;

   typedef struct {
      bit          v;
      logic [31:0] inst;
      logic [31:0] pc;
      bit          rdy;
      bit          eValid;
      bit          eReady;
      logic [31:0] eImm;
      logic [31:0] ePc;
      logic [2:0]  eFmt;
      int          eStall;
      bit          eIll;
   } vec_t;

   vec_t vecs[10];

   id_stage_ctrl #(.PC_W(PC_W), .STALL_CNT_W(SW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_if_valid   (ifValid),
      .o_if_ready   (ifReady),
      .i_if_inst    (ifInst),
      .i_if_pc      (ifPc),
      .i_flush      (flush),
      .o_id_valid   (idValid),
      .i_id_ready   (idReady),
      .o_id_inst    (idInst),
      .o_id_pc      (idPc),
      .o_id_imm     (idImm),
      .o_id_fmt     (idFmt),
      .o_id_illegal (idIllegal),
      .o_stall_cnt  (stallCnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] refFmt(input logic [6:0] op);
      case (op)
         7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
         7'h23:                      return 3'd2;
         7'h63:                      return 3'd3;
         7'h37, 7'h17:               return 3'd4;
         7'h6F:                      return 3'd5;
         default:                    return 3'd0;
      endcase
   endfunction

   // Gather the immediate's bits into a right-aligned value, then sign-extend by shifting.
   function automatic logic [31:0] refImm(input logic [31:0] x);
      logic [31:0]        raw;
      logic signed [31:0] t;
      int                 width;
      raw = '0;
      width = 32;
      case (refFmt(x[6:0]))
         3'd1: begin raw = x >> 20; width = 12; end
         3'd2: begin raw = ((x >> 25) << 5) | ((x >> 7) & 32'd31); width = 12; end
         3'd3: begin
            raw = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                  (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
            width = 13;
         end
         3'd4: return x & 32'hFFFFF000;
         3'd5: begin
            raw = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                  (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
            width = 21;
         end
         default: return 32'd0;
      endcase
      t = raw << (32 - width);
      return t >>> (32 - width);
   endfunction

   function automatic bit refIllegal(input logic [31:0] x);
`ifdef DEC_ILLEGAL_EN
      return (refFmt(x[6:0]) == 3'd0) && (x[6:0] != 7'h33);
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkAgainstModel();
      checkOutput("if_ready", ifReady, (q.size() < 2) && !flush);
      checkOutput("id_valid", idValid, q.size() > 0);
      if (q.size() > 0) begin
         checkOutput("id_inst", idInst, q[0].inst);
         checkOutput("id_pc", idPc, q[0].pc);
         checkOutput("id_imm", idImm, refImm(q[0].inst));
         checkOutput("id_fmt", idFmt, refFmt(q[0].inst[6:0]));
         checkOutput("id_illegal", idIllegal, refIllegal(q[0].inst));
      end
      checkOutput("stall_cnt", stallCnt, mStall);
   endtask

   // Entries leave from the front, arrive at the back; flush empties everything.
   task automatic modelEdge();
      bit doPush;
      bit doPop;
      doPush = ifValid && (q.size() < 2) && !flush;
      doPop  = (q.size() > 0) && idReady;
      if ((q.size() > 0) && !idReady && (mStall < SAT)) mStall++;
      if (flush) begin
         q.delete();
      end else begin
         if (doPop) void'(q.pop_front());
         if (doPush) q.push_back('{ifInst, ifPc});
      end
   endtask

   task automatic applyReset();
      ifValid = 1'b0;
      flush   = 1'b0;
      idReady = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset id_valid", idValid, 1'b0);
      checkOutput("reset id_inst", idInst, 32'd0);
      checkOutput("reset id_pc", idPc, 32'd0);
      checkOutput("reset id_imm", idImm, 32'd0);
      checkOutput("reset id_fmt", idFmt, 3'd0);
      checkOutput("reset id_illegal", idIllegal, 1'b0);
      checkOutput("reset stall_cnt", stallCnt, 0);
      checkOutput("reset if_ready", ifReady, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      mStall = 0;
   endtask

   task automatic applyStimulus(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                                input bit rdy, input bit fl);
      ifValid = v;
      ifInst  = inst;
      ifPc    = pc;
      idReady = rdy;
      flush   = fl;
   endtask

   initial begin
      logic [31:0] tmp;
      logic [6:0]  opList[11];
      opList = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

      vecs[0] = '{1, 32'hFFF00093, 32'h100, 1, 0, 1, 32'h0,        32'h0,   3'd0, 0, 0};
      vecs[1] = '{0, 32'h0,        32'h0,   1, 1, 1, 32'hFFFFFFFF, 32'h100, 3'd1, 0, 0};
      vecs[2] = '{1, 32'h12345037, 32'h104, 0, 0, 1, 32'h0,        32'h0,   3'd0, 0, 0};
      vecs[3] = '{1, 32'hFE000EE3, 32'h108, 0, 1, 1, 32'h12345000, 32'h104, 3'd4, 0, 0};
      vecs[4] = '{1, 32'h0,        32'h10C, 0, 1, 0, 32'h12345000, 32'h104, 3'd4, 1, 0};
      vecs[5] = '{0, 32'h0,        32'h0,   1, 1, 0, 32'h12345000, 32'h104, 3'd4, 2, 0};
      vecs[6] = '{0, 32'h0,        32'h0,   0, 1, 1, 32'hFFFFFFFC, 32'h108, 3'd3, 2, 0};
      vecs[7] = '{0, 32'h0,        32'h0,   1, 1, 1, 32'hFFFFFFFC, 32'h108, 3'd3, 3, 0};
      vecs[8] = '{1, 32'h0000007F, 32'h200, 1, 0, 1, 32'h0,        32'h0,   3'd0, 3, 0};
      vecs[9] = '{0, 32'h0,        32'h0,   1, 1, 1, 32'h0,        32'h200, 3'd0, 3, 1};

      applyReset();

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].rdy, 1'b0);
         @(negedge clk);
         checkOutput($sformatf("vec%0d id_valid", i), idValid, vecs[i].eValid);
         checkOutput($sformatf("vec%0d if_ready", i), ifReady, vecs[i].eReady);
         checkOutput($sformatf("vec%0d stall_cnt", i), stallCnt, vecs[i].eStall);
         if (vecs[i].eValid) begin
            checkOutput($sformatf("vec%0d id_imm", i), idImm, vecs[i].eImm);
            checkOutput($sformatf("vec%0d id_pc", i), idPc, vecs[i].ePc);
            checkOutput($sformatf("vec%0d id_fmt", i), idFmt, vecs[i].eFmt);
`ifdef DEC_ILLEGAL_EN
            checkOutput($sformatf("vec%0d id_illegal", i), idIllegal, vecs[i].eIll);
`else
            checkOutput($sformatf("vec%0d id_illegal", i), idIllegal, 1'b0);
`endif
         end
         @(posedge clk);
         #1;
      end

      // Flush while FULL: nothing from the skid entry may emerge afterwards.
      applyStimulus(1, 32'h00100093, 32'h300, 0, 0);
      @(posedge clk); #1;
      applyStimulus(1, 32'h00200093, 32'h304, 0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("full if_ready", ifReady, 1'b0);
      checkOutput("full id_valid", idValid, 1'b1);
      applyStimulus(1, 32'h00300093, 32'h308, 0, 1);
      @(negedge clk);
      checkOutput("flush if_ready", ifReady, 1'b0);
      @(posedge clk); #1;
      applyStimulus(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      checkOutput("post-flush id_valid", idValid, 1'b0);
      checkOutput("post-flush if_ready", ifReady, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("post-flush skid gone", idValid, 1'b0);
      @(posedge clk); #1;

      // Stall counter saturation and survival across flush.
      applyReset();
      applyStimulus(1, 32'h00000013, 32'h400, 0, 0);
      @(posedge clk); #1;
      applyStimulus(0, 32'h0, 32'h0, 0, 0);
      repeat (SAT - 1) @(posedge clk);
      #1;
      checkOutput("stall pre-sat", stallCnt, SAT - 1);
      repeat (SAT + 5 - (SAT - 1)) @(posedge clk);
      #1;
      checkOutput("stall saturated", stallCnt, SAT);
      applyStimulus(0, 32'h0, 32'h0, 0, 1);
      @(posedge clk); #1;
      applyStimulus(0, 32'h0, 32'h0, 0, 0);
      checkOutput("stall kept by flush", stallCnt, SAT);
      checkOutput("flush drops valid", idValid, 1'b0);

      // Asynchronous reset while FULL.
      applyReset();
      applyStimulus(1, 32'h00500013, 32'h500, 0, 0);
      @(posedge clk); #1;
      applyStimulus(1, 32'h00600013, 32'h504, 0, 0);
      @(posedge clk); #1;
      applyStimulus(0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      checkOutput("pre-reset id_valid", idValid, 1'b1);
      checkOutput("pre-reset if_ready", ifReady, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset id_valid", idValid, 1'b0);
      checkOutput("async reset if_ready", ifReady, 1'b1);
      checkOutput("async reset stall_cnt", stallCnt, 0);

      // Randomized traffic against the queue model.
      applyReset();
      for (int c = 0; c < 3000; c++) begin
         tmp = $urandom();
         tmp[6:0] = opList[$urandom_range(0, 10)];
         applyStimulus($urandom_range(0, 9) < 7, tmp, $urandom(),
                       $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
         @(negedge clk);
         checkAgainstModel();
         @(posedge clk);
         modelEdge();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
